// File: rtl/control_pkg.sv
// Shared encodings for the LEGv8 main control decoder: opcodes, ALU-op codes
// and the bundled control word.
package control_pkg;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // CBZ matches on opcode[10:3] and B on opcode[10:5]; the low bits are immediate
  localparam logic [7:0] OP_CBZ_PFX = 8'b1011_0100;
  localparam logic [5:0] OP_B_PFX   = 6'b00_0101;

  typedef enum logic [1:0] {
    ALU_OP_MEM   = 2'b00,
    ALU_OP_CBZ   = 2'b01,
    ALU_OP_RTYPE = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg2_loc;
    logic    uncondbranch;
    logic    branch;
    logic    mem_read;
    logic    mem_to_reg;
    alu_op_e alu_op;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg2_loc:     1'b0,
    uncondbranch: 1'b0,
    branch:       1'b0,
    mem_read:     1'b0,
    mem_to_reg:   1'b0,
    alu_op:       ALU_OP_MEM,
    mem_write:    1'b0,
    alu_src:      1'b0,
    reg_write:    1'b0
  };

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode decoder producing the control word and an
// illegal-opcode flag; unknown opcodes decode to NOP.
module control_decode
  import control_pkg::*;
(
  input  logic [10:0] opcode,
  output ctrl_t       ctrl,
  output logic        illegal
);

  // Opcode to control-word decode, NOP unless a supported pattern matches
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        ctrl.alu_op    = ALU_OP_RTYPE;
        ctrl.reg_write = 1'b1;
      end
      OP_LDUR: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_STUR: begin
        ctrl.reg2_loc  = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      default: begin
        if (opcode[10:3] == OP_CBZ_PFX) begin
          ctrl.reg2_loc = 1'b1;
          ctrl.branch   = 1'b1;
          ctrl.alu_op   = ALU_OP_CBZ;
        end else if (opcode[10:5] == OP_B_PFX) begin
          ctrl.uncondbranch = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// LEGv8 main control unit: decode plus sticky illegal-opcode status.
// Define CONTROL_OUT_REG_EN to register the control outputs (1-cycle latency).
module control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  output logic        reg2_loc,
  output logic        uncondbranch,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic        illegal_op,
  output logic        illegal_seen
);

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  ctrl_t out_ctrl;
  logic  out_illegal;
  logic  illegal_seen_d;
  logic  illegal_seen_q;

  control_decode u_decode (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

`ifdef CONTROL_OUT_REG_EN
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  illegal_d;
  logic  illegal_q;

  always_comb begin
    ctrl_d    = dec_ctrl;
    illegal_d = dec_illegal;
  end

  // Output pipeline register, resets to NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_NOP;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_ctrl    = ctrl_q;
  assign out_illegal = illegal_q;
`else
  assign out_ctrl    = dec_ctrl;
  assign out_illegal = dec_illegal;
`endif

  always_comb begin
    illegal_seen_d = illegal_seen_q | out_illegal;
  end

  // Sticky status: only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign reg2_loc     = out_ctrl.reg2_loc;
  assign uncondbranch = out_ctrl.uncondbranch;
  assign branch       = out_ctrl.branch;
  assign mem_read     = out_ctrl.mem_read;
  assign mem_to_reg   = out_ctrl.mem_to_reg;
  assign alu_op       = out_ctrl.alu_op;
  assign mem_write    = out_ctrl.mem_write;
  assign alu_src      = out_ctrl.alu_src;
  assign reg_write    = out_ctrl.reg_write;
  assign illegal_op   = out_illegal;
  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; follows CONTROL_OUT_REG_EN
// to sample either combinationally or one clock after the opcode is applied.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [10:0] opcode;
  logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg;
  logic [1:0]  alu_op;
  logic        mem_write, alu_src, reg_write, illegal_op, illegal_seen;

  int checks;
  int errors;

  // Expected vector order: reg2_loc,uncondbranch,branch,mem_read,mem_to_reg,alu_op[1:0],mem_write,alu_src,reg_write,illegal_op
  localparam logic [10:0] V_RTYPE = 11'b0_0_0_0_0_10_0_0_1_0;
  localparam logic [10:0] V_LDUR  = 11'b0_0_0_1_1_00_0_1_1_0;
  localparam logic [10:0] V_STUR  = 11'b1_0_0_0_0_00_1_1_0_0;
  localparam logic [10:0] V_CBZ   = 11'b1_0_1_0_0_01_0_0_0_0;
  localparam logic [10:0] V_B     = 11'b0_1_0_0_0_00_0_0_0_0;
  localparam logic [10:0] V_ILL   = 11'b0_0_0_0_0_00_0_0_0_1;
  localparam logic [10:0] V_NOP   = 11'b0_0_0_0_0_00_0_0_0_0;

  control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .reg2_loc     (reg2_loc),
    .uncondbranch (uncondbranch),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .alu_op       (alu_op),
    .mem_write    (mem_write),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .illegal_op   (illegal_op),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, alu_op,
           mem_write, alu_src, reg_write, illegal_op};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_seen(input string tag, input logic exp);
    checks++;
    assert (illegal_seen === exp) else begin
      errors++;
      $error("FAIL %s illegal_seen observed=%b expected=%b", tag, illegal_seen, exp);
    end
  endtask

  // Drive at the falling edge, then sample once the output is valid
  task automatic apply(input logic [10:0] op);
    @(negedge clk);
    opcode = op;
`ifdef CONTROL_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    opcode = 11'h458;
    #22;
    check_seen("reset_seen", 1'b0);
`ifdef CONTROL_OUT_REG_EN
    check_vec("reset_nop", V_NOP);
`else
    check_vec("reset_follows_opcode", V_RTYPE);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CONTROL_OUT_REG_EN
    // Latency: output still reflects the previous opcode before the edge
    @(posedge clk);
    #1;
    @(negedge clk);
    opcode = 11'h7C2;
    #1;
    check_vec("latency_hold", V_RTYPE);
    @(posedge clk);
    #1;
    check_vec("latency_update", V_LDUR);
`endif

    apply(11'h458); check_vec("add",   V_RTYPE);
    apply(11'h658); check_vec("sub",   V_RTYPE);
    apply(11'h450); check_vec("and",   V_RTYPE);
    apply(11'h550); check_vec("orr",   V_RTYPE);
    apply(11'h7C2); check_vec("ldur",  V_LDUR);
    apply(11'h7C0); check_vec("stur",  V_STUR);
    apply(11'h5A0); check_vec("cbz_lo", V_CBZ);
    apply(11'h5A7); check_vec("cbz_hi", V_CBZ);
    apply(11'h0A0); check_vec("b_lo",  V_B);
    apply(11'h0AF); check_vec("b_mid", V_B);
    apply(11'h0BF); check_vec("b_hi",  V_B);
    check_seen("seen_after_legal", 1'b0);

    apply(11'h765); check_vec("illegal_765", V_ILL);
    check_seen("seen_before_edge", 1'b0);
    @(posedge clk);
    #1;
    check_seen("seen_after_edge", 1'b1);

    apply(11'h458); check_vec("add_after_ill", V_RTYPE);
    check_seen("seen_sticky", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_seen("seen_sticky_later", 1'b1);

    // Asynchronous reset pulse mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_seen("seen_async_clear", 1'b0);
`ifdef CONTROL_OUT_REG_EN
    check_vec("async_nop", V_NOP);
`else
    check_vec("reset_comb_follows", V_RTYPE);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Pattern boundaries just outside each encoding
    apply(11'h5A8); check_vec("cbz_above", V_ILL);
    apply(11'h59F); check_vec("cbz_below", V_ILL);
    apply(11'h0C0); check_vec("b_above",   V_ILL);
    apply(11'h09F); check_vec("b_below",   V_ILL);
    apply(11'h7C1); check_vec("ldst_gap",  V_ILL);
    apply(11'h459); check_vec("add_plus1", V_ILL);
    @(posedge clk);
    #1;
    check_seen("seen_boundary", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main control decoder for the single-issue LEGv8 datapath; sits in the decode stage, fed by instruction bits [31:21].
- Decodes the 11-bit opcode into the datapath control signals consumed by the register file, ALU control, data memory and PC logic.
- Also flags unsupported opcodes and keeps a sticky illegal-opcode status bit.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  11  instruction[31:21]
- reg2_loc  output  1  read-register-2 select: 1 = Rt field, 0 = Rm field
- uncondbranch  output  1  unconditional branch (B)
- branch  output  1  conditional branch (CBZ)
- mem_read  output  1  data-memory read enable
- mem_to_reg  output  1  write-back select: 1 = memory data, 0 = ALU result
- alu_op  output  2  00 = add (address), 01 = pass/zero-test (CBZ), 10 = R-type (funct from opcode)
- mem_write  output  1  data-memory write enable
- alu_src  output  1  ALU operand B: 1 = sign-extended immediate, 0 = register
- reg_write  output  1  register-file write enable
- illegal_op  output  1  current opcode matches no supported instruction
- illegal_seen  output  1  sticky: an illegal opcode was presented on a clock edge since reset

Behaviour:
- Default build: all control outputs and illegal_op are purely combinational from opcode; zero latency; clk and rst_n do not affect them.
- Decode table, exact 11-bit match unless a range is given. Signal order: reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write.
  - ADD 0x458: 0,0,0,0,0,10,0,0,1
  - SUB 0x658: 0,0,0,0,0,10,0,0,1
  - AND 0x450: 0,0,0,0,0,10,0,0,1
  - ORR 0x550: 0,0,0,0,0,10,0,0,1
  - LDUR 0x7C2: 0,0,0,1,1,00,0,1,1
  - STUR 0x7C0: 1,0,0,0,0,00,1,1,0
  - CBZ 0x5A0–0x5A7 (opcode[10:3]=8'b10110100, low 3 bits ignored): 1,0,1,0,0,01,0,0,0
  - B 0x0A0–0x0BF (opcode[10:5]=6'b000101, low 5 bits ignored): 0,1,0,0,0,00,0,0,0
  - Any other value: all nine signals 0 (NOP) and illegal_op=1. illegal_op=0 for every row above.
- Patterns are disjoint, so no priority is needed. The outputs must have no X-propagation and no latches; the default assignment is NOP.
- Sticky bit:
  - illegal_seen resets to 0 asynchronously on rst_n low.
  - On each clk rising edge with rst_n high, illegal_seen <= illegal_seen | illegal_op.
  - It is cleared only by reset.
- Reset mid-operation: illegal_seen clears immediately. The combinational outputs continue to follow opcode.

Optional Feature:
- Macro CONTROL_OUT_REG_EN.
- Defined: all nine control outputs and illegal_op are registered on clk rising edge, giving 1-cycle latency from opcode.
  - On rst_n low they go asynchronously to NOP (all 0, alu_op=00) with illegal_op=0.
  - illegal_seen then accumulates the registered illegal_op, so it asserts 2 edges after an illegal opcode.
- Undefined: the combinational behaviour above.

Decomposition:
- Package control_pkg contains:
  - 11-bit opcode constants OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR.
  - Prefix constants OP_CBZ_PFX (8 bits) and OP_B_PFX (6 bits).
  - alu_op enum: ALU_OP_MEM=00, ALU_OP_CBZ=01, ALU_OP_RTYPE=10.
  - Packed struct ctrl_t holding the nine signals, plus constant CTRL_NOP.
- Sub-module control_decode: purely combinational opcode -> ctrl_t plus illegal flag.
- control_unit instantiates control_decode and adds the sticky register and the optional output register.

Test Plan:
- ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550 -> alu_op=10, reg_write=1, all other signals 0, illegal_op=0.
- LDUR 0x7C2 -> mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00, rest 0.
- STUR 0x7C0 -> reg2_loc=1, mem_write=1, alu_src=1, alu_op=00, rest 0.
- CBZ 0x5A0 and 0x5A7 -> reg2_loc=1, branch=1, alu_op=01, rest 0.
- B 0x0A0 and 0x0AF -> only uncondbranch=1.
- Illegal opcodes:
  - Reset, then apply 0x765 -> all signals 0, illegal_op=1; illegal_seen=1 after the next clk edge.
  - Then apply 0x458 -> illegal_seen stays 1.
  - Pulse rst_n low -> illegal_seen=0 immediately.
  - Repeat the table with CONTROL_OUT_REG_EN defined, checking 1-cycle latency.
